// File: rtl/shift_row_byte_sub.sv
// shift_row_byte_sub
//
// Forward AES round helper: SubBytes followed by ShiftRows, applied in place
// to the 16-byte cipher state held in the external statemt word memory.
// Byte (row r, column c) lives at word r+4c, bits [7:0]. The block first
// reads all 16 bytes into a local buffer and only then writes the
// transformed state back, so overwriting the source words is safe.
//
// Sequence after the start-accept edge T:
//   RD   T+1..T+8   : two reads per cycle (words 2k, 2k+1)
//   RDW  T+9        : last read pair lands in the buffer
//   WR   T+10..T+17 : two writes per cycle (words 2k, 2k+1)
//   DONE T+18       : ap_done / ap_ready pulse
//
// Configuration macro:
//   SRBS_SUBBYTES_EN  defined   -> full SubBytes + ShiftRows (forward S-box ROM)
//                     undefined -> ShiftRows only (identity substitution, no ROM)
//
// Ports:
//   ap_clk, ap_rst              clock, asynchronous active-high reset
//   ap_start                    start request, sampled while idle
//   ap_done, ap_idle, ap_ready  ap_ctrl_hs handshake outputs (registered)
//   statemt_address0/1 [4:0]    word address, ports 0/1 (registered)
//   statemt_ce0/1, statemt_we0/1 enable / write enable (registered)
//   statemt_d0/1 [31:0]         write data, upper 24 bits always 0 (registered)
//   statemt_q0/1 [31:0]         read data, one cycle after a read request

module shift_row_byte_sub (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [4:0]  statemt_address0,
  output logic        statemt_ce0,
  output logic        statemt_we0,
  output logic [31:0] statemt_d0,
  input  logic [31:0] statemt_q0,
  output logic [4:0]  statemt_address1,
  output logic        statemt_ce1,
  output logic        statemt_we1,
  output logic [31:0] statemt_d1,
  input  logic [31:0] statemt_q1
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_RDW  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

`ifdef SRBS_SUBBYTES_EN
  // FIPS-197 forward S-box, index 0 first.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
`endif

  // Byte substitution: S-box lookup, or pass-through for the ShiftRows-only build.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
`ifdef SRBS_SUBBYTES_EN
    return SBOX[b];
`else
    return b;
`endif
  endfunction

  // Source word for destination word w = {c, r}: row r rotates left by r,
  // so the byte comes from column (c + r) mod 4 of the same row.
  function automatic logic [3:0] src_word(input logic [3:0] w);
    logic [1:0] col;
    col = w[3:2] + w[1:0];
    return {col, w[1:0]};
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [2:0]  step_r;
  logic [2:0]  step_nxt_s;
  logic [7:0]  buf_r [16];

  logic        capture_s;
  logic [2:0]  cap_idx_s;
  logic [3:0]  word0_s;
  logic [3:0]  word1_s;

  logic        ce_nxt_s;
  logic        we_nxt_s;
  logic [4:0]  addr0_nxt_s;
  logic [4:0]  addr1_nxt_s;
  logic [31:0] d0_nxt_s;
  logic [31:0] d1_nxt_s;

  // Only the low byte of each read word carries state.
  logic        unused_q_s;
  assign unused_q_s = ^{statemt_q0[31:8], statemt_q1[31:8]};

  // Next-state and step-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    step_nxt_s  = step_r;
    case (state_r)
      ST_IDLE: begin
        step_nxt_s = 3'd0;
        if (ap_start) begin
          state_nxt_s = ST_RD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (step_r == 3'd7) begin
          state_nxt_s = ST_RDW;
          step_nxt_s  = step_r;
        end else begin
          state_nxt_s = ST_RD;
          step_nxt_s  = step_r + 3'd1;
        end
      end
      ST_RDW: begin
        state_nxt_s = ST_WR;
        step_nxt_s  = 3'd0;
      end
      ST_WR: begin
        if (step_r == 3'd7) begin
          state_nxt_s = ST_DONE;
          step_nxt_s  = 3'd0;
        end else begin
          state_nxt_s = ST_WR;
          step_nxt_s  = step_r + 3'd1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        step_nxt_s  = 3'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        step_nxt_s  = 3'd0;
      end
    endcase
  end

  // Read data requested in step k arrives during step k+1 (or RDW for k=7).
  always_comb begin
    capture_s = 1'b0;
    cap_idx_s = 3'd0;
    if (state_r == ST_RDW) begin
      capture_s = 1'b1;
      cap_idx_s = 3'd7;
    end else if ((state_r == ST_RD) && (step_r != 3'd0)) begin
      capture_s = 1'b1;
      cap_idx_s = step_r - 3'd1;
    end else begin
      capture_s = 1'b0;
      cap_idx_s = 3'd0;
    end
  end

  assign word0_s = {step_nxt_s, 1'b0};
  assign word1_s = {step_nxt_s, 1'b1};

  // Memory-port values for the coming cycle; registered below.
  // The WR k=0 data is formed on the same edge that captures words 14/15,
  // which is safe: words 0 and 1 draw from words 0 and 5 only.
  always_comb begin
    ce_nxt_s    = 1'b0;
    we_nxt_s    = 1'b0;
    addr0_nxt_s = 5'd0;
    addr1_nxt_s = 5'd0;
    d0_nxt_s    = 32'd0;
    d1_nxt_s    = 32'd0;
    case (state_nxt_s)
      ST_RD: begin
        ce_nxt_s    = 1'b1;
        addr0_nxt_s = {1'b0, word0_s};
        addr1_nxt_s = {1'b0, word1_s};
      end
      ST_WR: begin
        ce_nxt_s    = 1'b1;
        we_nxt_s    = 1'b1;
        addr0_nxt_s = {1'b0, word0_s};
        addr1_nxt_s = {1'b0, word1_s};
        d0_nxt_s    = {24'd0, sub_byte(buf_r[src_word(word0_s)])};
        d1_nxt_s    = {24'd0, sub_byte(buf_r[src_word(word1_s)])};
      end
      default: begin
        ce_nxt_s    = 1'b0;
        we_nxt_s    = 1'b0;
      end
    endcase
  end

  // FSM state and step counter.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r <= ST_IDLE;
      step_r  <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      step_r  <= step_nxt_s;
    end
  end

  // Local copy of the 16 state bytes.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < 16; i++) begin
        buf_r[i] <= 8'h00;
      end
    end else if (capture_s) begin
      buf_r[{cap_idx_s, 1'b0}] <= statemt_q0[7:0];
      buf_r[{cap_idx_s, 1'b1}] <= statemt_q1[7:0];
    end
  end

  // Registered handshake and memory-port outputs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ap_idle          <= 1'b1;
      ap_done          <= 1'b0;
      ap_ready         <= 1'b0;
      statemt_ce0      <= 1'b0;
      statemt_we0      <= 1'b0;
      statemt_address0 <= 5'd0;
      statemt_d0       <= 32'd0;
      statemt_ce1      <= 1'b0;
      statemt_we1      <= 1'b0;
      statemt_address1 <= 5'd0;
      statemt_d1       <= 32'd0;
    end else begin
      ap_idle          <= (state_nxt_s == ST_IDLE);
      ap_done          <= (state_nxt_s == ST_DONE);
      ap_ready         <= (state_nxt_s == ST_DONE);
      statemt_ce0      <= ce_nxt_s;
      statemt_we0      <= we_nxt_s;
      statemt_address0 <= addr0_nxt_s;
      statemt_d0       <= d0_nxt_s;
      statemt_ce1      <= ce_nxt_s;
      statemt_we1      <= we_nxt_s;
      statemt_address1 <= addr1_nxt_s;
      statemt_d1       <= d1_nxt_s;
    end
  end

endmodule

// File: tb/tb_shift_row_byte_sub.sv
// Self-checking bench for shift_row_byte_sub. The bench plays the role of the
// 32x32 statemt memory (two ports, one-cycle read latency) and predicts the
// result with an AES reference whose S-box is computed from GF(2^8)
// inversion plus the affine map. Follows SRBS_SUBBYTES_EN like the design.

module tb_shift_row_byte_sub;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [4:0]  statemt_address0;
  logic        statemt_ce0;
  logic        statemt_we0;
  logic [31:0] statemt_d0;
  logic [31:0] statemt_q0;
  logic [4:0]  statemt_address1;
  logic        statemt_ce1;
  logic        statemt_we1;
  logic [31:0] statemt_d1;
  logic [31:0] statemt_q1;

  shift_row_byte_sub dut (
    .ap_clk           (ap_clk),
    .ap_rst           (ap_rst),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .statemt_address0 (statemt_address0),
    .statemt_ce0      (statemt_ce0),
    .statemt_we0      (statemt_we0),
    .statemt_d0       (statemt_d0),
    .statemt_q0       (statemt_q0),
    .statemt_address1 (statemt_address1),
    .statemt_ce1      (statemt_ce1),
    .statemt_we1      (statemt_we1),
    .statemt_d1       (statemt_d1),
    .statemt_q1       (statemt_q1)
  );

  always #5 ap_clk = ~ap_clk;

  logic [31:0] mem [32];
  logic [31:0] snap [16];
  logic [31:0] hi_snap [16];
  logic [31:0] exp_st [16];
  logic [7:0]  sb_tab [256];
  int          n_checks = 0;
  int          n_fail = 0;
  int          oob_cnt = 0;
  int          hi_d_cnt = 0;

  // Memory model: port 0 then port 1; reads return one cycle later.
  always @(posedge ap_clk) begin
    if (statemt_ce0 && statemt_we0) mem[statemt_address0] <= statemt_d0;
    if (statemt_ce0 && !statemt_we0) statemt_q0 <= mem[statemt_address0];
    if (statemt_ce1 && statemt_we1) mem[statemt_address1] <= statemt_d1;
    if (statemt_ce1 && !statemt_we1) statemt_q1 <= mem[statemt_address1];
    oob_cnt <= oob_cnt + int'(statemt_ce0 && statemt_address0[4])
                       + int'(statemt_ce1 && statemt_address1[4]);
    hi_d_cnt <= hi_d_cnt + int'(statemt_ce0 && statemt_we0 && (statemt_d0[31:8] != 24'd0))
                         + int'(statemt_ce1 && statemt_we1 && (statemt_d1[31:8] != 24'd0));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse, then affine map.
  function automatic logic [7:0] calc_sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] t;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (b != 8'h00 && gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    end
    s = inv ^ 8'h63;
    for (int n = 1; n <= 4; n++) begin
      t = (inv << n) | (inv >> (8 - n));
      s = s ^ t;
    end
    return s;
  endfunction

  function automatic logic [7:0] model_sub(input logic [7:0] b);
`ifdef SRBS_SUBBYTES_EN
    return sb_tab[b];
`else
    return b;
`endif
  endfunction

  // exp_st = SubBytes(ShiftRows(snap)) in the column-major word layout.
  task automatic model_run();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_st[r + 4 * c] = {24'd0, model_sub(snap[r + 4 * ((c + r) % 4)][7:0])};
  endtask

  task automatic preload(input int mode, input logic [31:0] fill);
    for (int i = 0; i < 32; i++) begin
      if (mode == 0)      mem[i] <= 32'(i);
      else if (mode == 1) mem[i] <= fill;
      else                mem[i] <= $urandom;
    end
    @(posedge ap_clk); #1;
    for (int i = 0; i < 16; i++) begin
      snap[i]    = mem[i];
      hi_snap[i] = mem[i + 16];
    end
  endtask

  // Starts one run from IDLE; lat = cycle index (accept edge = T) of ap_done.
  task automatic run_once(output int lat);
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    lat = 1;
    while (!ap_done && lat < 40) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("%s_w%0d", tag, i), mem[i], exp_st[i]);
      check_eq($sformatf("%s_hi%0d", tag, i), mem[i + 16], hi_snap[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_idle"}, 32'(ap_idle), 32'd1);
    check_eq({tag, "_done"}, 32'(ap_done), 32'd0);
    check_eq({tag, "_ready"}, 32'(ap_ready), 32'd0);
    check_eq({tag, "_ce"}, {30'd0, statemt_ce1, statemt_ce0}, 32'd0);
    check_eq({tag, "_we"}, {30'd0, statemt_we1, statemt_we0}, 32'd0);
    check_eq({tag, "_addr"}, {22'd0, statemt_address1, statemt_address0}, 32'd0);
    check_eq({tag, "_d0"}, statemt_d0, 32'd0);
    check_eq({tag, "_d1"}, statemt_d1, 32'd0);
  endtask

  initial begin
    int lat;
    int cnt;
    int done_at [$];
    int idle_cnt;
    int ready_bad;
    logic [31:0] ident_exp [8];
    logic [31:0] tmp;

    ap_rst   = 1'b1;
    ap_start = 1'b0;
    for (int i = 0; i < 256; i++) sb_tab[i] = calc_sbox(8'(i));
    ident_exp = '{32'h00, 32'h05, 32'h0a, 32'h0f, 32'h04, 32'h09, 32'h0e, 32'h03};

    repeat (2) @(posedge ap_clk);
    #1;
    check_reset_outputs("rst");
    ap_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk); #1;
      check_eq($sformatf("idle_%0d", i), {29'd0, ap_idle, ap_done, statemt_ce0 | statemt_ce1}, 32'h4);
    end

    // Counting pattern statemt[i] = i.
    preload(0, 32'd0);
    model_run();
    run_once(lat);
    check_eq("cnt_latency", 32'(lat), 32'd18);
    check_state("cnt");
`ifdef SRBS_SUBBYTES_EN
    check_eq("cnt_fix0", mem[0], 32'h63);
    check_eq("cnt_fix1", mem[1], 32'h6b);
    check_eq("cnt_fix2", mem[2], 32'h67);
    check_eq("cnt_fix3", mem[3], 32'h76);
`else
    for (int i = 0; i < 8; i++) check_eq($sformatf("cnt_fix%0d", i), mem[i], ident_exp[i]);
`endif

    // Uniform 0xFFFFFF53 fill: upper bits must be dropped.
    preload(1, 32'hFFFF_FF53);
    model_run();
    run_once(lat);
    check_eq("u53_latency", 32'(lat), 32'd18);
    check_state("u53");
`ifdef SRBS_SUBBYTES_EN
    check_eq("u53_fix", mem[9], 32'h0000_00ed);
`else
    check_eq("u53_fix", mem[9], 32'h0000_0053);
`endif

    // Random states.
    for (int t = 0; t < 4; t++) begin
      preload(2, 32'd0);
      model_run();
      run_once(lat);
      check_eq($sformatf("rnd%0d_latency", t), 32'(lat), 32'd18);
      check_state($sformatf("rnd%0d", t));
    end

    // Back-to-back with ap_start held high: second run transforms the first's output.
    preload(2, 32'd0);
    model_run();
    for (int i = 0; i < 16; i++) snap[i] = exp_st[i];
    model_run();
    ap_start  = 1'b1;
    cnt       = 0;
    idle_cnt  = 0;
    ready_bad = 0;
    while (done_at.size() < 2 && cnt < 100) begin
      @(posedge ap_clk); #1;
      cnt++;
      if (ap_ready !== ap_done) ready_bad++;
      if (ap_idle) idle_cnt++;
      if (ap_done) begin
        done_at.push_back(cnt);
        if (done_at.size() == 2) ap_start = 1'b0;
      end
    end
    ap_start = 1'b0;
    @(posedge ap_clk); #1;
    check_eq("b2b_count", 32'(done_at.size()), 32'd2);
    if (done_at.size() == 2) begin
      check_eq("b2b_first", 32'(done_at[0]), 32'd18);
      // DONE cycle plus one IDLE cycle: 19 cycles between completions.
      check_eq("b2b_period", 32'(done_at[1] - done_at[0]), 32'd19);
    end
    check_eq("b2b_idle_cycles", 32'(idle_cnt), 32'd1);
    check_eq("b2b_ready", 32'(ready_bad), 32'd0);
    check_state("b2b");

    // Reset right after the WR k=3 writes (words 6, 7) have committed.
    preload(2, 32'd0);
    model_run();
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    cnt = 0;
    while (!(statemt_we0 && statemt_address0 == 5'd6) && cnt < 40) begin
      @(posedge ap_clk); #1;
      cnt++;
    end
    check_eq("mid_found_wr3", 32'(cnt < 40), 32'd1);
    @(posedge ap_clk); #1;
    ap_rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    for (int i = 0; i < 16; i++) begin
      tmp = (i < 8) ? exp_st[i] : snap[i];
      check_eq($sformatf("mid_w%0d", i), mem[i], tmp);
    end
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    model_run();
    run_once(lat);
    check_eq("mid_restart_latency", 32'(lat), 32'd18);
    check_state("mid_restart");

    check_eq("oob_access", 32'(oob_cnt), 32'd0);
    check_eq("d_upper_bits", 32'(hi_d_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
